pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 37 +++
 rtl/drain_counter.sv | 38 +++
 rtl/pipe_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/redirect controller: cause codes,
// default fence drain depth, FSM state type and the trap-target selector.
package pipe_ctrl_pkg;

  localparam int unsigned FENCE_DEPTH_DEFAULT = 3;

  localparam logic [63:0] CAUSE_BREAKPOINT   = 64'd3;
  localparam logic [63:0] CAUSE_ECALL_FROM_U = 64'd8;
  localparam logic [63:0] CAUSE_ECALL_FROM_S = 64'd9;
  localparam logic [63:0] CAUSE_ECALL_FROM_M = 64'd11;
  // xRET is routed through the trap path with private codes outside the mcause range.
  localparam logic [63:0] CAUSE_MRET         = 64'h0000_0000_0000_0100;
  localparam logic [63:0] CAUSE_SRET         = 64'h0000_0000_0000_0101;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StBusy  = 2'd1,
    StFence = 2'd2,
    StTrap  = 2'd3
  } ctrl_state_e;

  function automatic logic [63:0] trap_target(input logic [63:0] cause,
                                              input logic [63:0] mtvec,
                                              input logic [63:0] mepc,
                                              input logic [63:0] sepc);
    logic [63:0] tgt;
    if (cause == CAUSE_MRET) begin
      tgt = mepc;
    end else if (cause == CAUSE_SRET) begin
      tgt = sepc;
    end else begin
      tgt = mtvec;
    end
    return tgt;
  endfunction

endpackage

// File: rtl/drain_counter.sv
// Down-counter used to time the fence drain: load, decrement (saturating at 0), clear.
module drain_counter #(
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Flags the value after this cycle's update, so the owner can leave on the last decrement.
  assign zero_o = (cnt_d == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stalls, bubbles, flushes and PC redirects for load-use, branches,
// multi-cycle EX ops, fences and traps.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FENCE_DEPTH = FENCE_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_use_i,
  input  logic        branch_flush_i,
  input  logic [63:0] branch_target_i,
  input  logic        fence_i,
  input  logic        exception_i,
  input  logic [63:0] cause_i,
  input  logic [63:0] pc_i,
  input  logic [63:0] mtvec_i,
  input  logic [63:0] mepc_i,
  input  logic [63:0] sepc_i,
  input  logic        ex_busy_i,
  output logic        stall_if_o,
  output logic        stall_id_o,
  output logic        stall_ex_o,
  output logic        bubble_ex_o,
  output logic        flush_if_o,
  output logic        flush_all_o,
  output logic        redirect_o,
  output logic [63:0] redirect_pc_o,
  output logic [63:0] epc_o,
  output logic [63:0] stall_cnt_o
);

  localparam int unsigned CntW = (FENCE_DEPTH < 1) ? 1 : $clog2(FENCE_DEPTH + 1);

  ctrl_state_e state_q, state_d;
  logic [63:0] target_q, target_d;
  logic [63:0] epc_q, epc_d;
  logic [63:0] stall_cnt_q, stall_cnt_d;

  logic stall_if, stall_id, stall_ex, bubble_ex, flush_if, flush_all, redirect, branch_sel;
  logic cnt_load, cnt_dec, cnt_clr, cnt_zero, latch_trap;

  drain_counter #(
    .Width (CntW)
  ) u_drain_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (CntW'(FENCE_DEPTH)),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    stall_ex   = 1'b0;
    bubble_ex  = 1'b0;
    flush_if   = 1'b0;
    flush_all  = 1'b0;
    redirect   = 1'b0;
    branch_sel = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cnt_clr    = 1'b0;
    latch_trap = 1'b0;

    unique case (state_q)
      StRun, StBusy, StFence: begin
        if (exception_i) begin
          // Any in-flight busy wait or fence drain is abandoned in favour of the trap.
          flush_all  = 1'b1;
          latch_trap = 1'b1;
          cnt_clr    = 1'b1;
          state_d    = StTrap;
        end else if (state_q == StFence) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
          cnt_dec   = 1'b1;
          if (cnt_zero) begin
            state_d = StRun;
          end
        end else if (state_q == StBusy) begin
          if (ex_busy_i) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            stall_ex = 1'b1;
          end else begin
            state_d = StRun;
          end
        end else if (ex_busy_i) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          stall_ex = 1'b1;
          state_d  = StBusy;
        end else if (fence_i) begin
          cnt_load = 1'b1;
          if (FENCE_DEPTH != 0) begin
            state_d = StFence;
          end
        end else if (load_use_i) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
        end else if (branch_flush_i) begin
          flush_if   = 1'b1;
          redirect   = 1'b1;
          branch_sel = 1'b1;
        end
      end
      StTrap: begin
        redirect  = 1'b1;
        flush_all = 1'b1;
        state_d   = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    target_d    = target_q;
    epc_d       = epc_q;
    stall_cnt_d = stall_cnt_q;
    if (latch_trap) begin
      target_d = trap_target(cause_i, mtvec_i, mepc_i, sepc_i);
      epc_d    = pc_i;
    end
    if (stall_if && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      target_q    <= '0;
      epc_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      epc_q       <= epc_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // RUN decodes straight from inputs, so outputs are masked while reset is held.
  assign stall_if_o    = rst_n & stall_if;
  assign stall_id_o    = rst_n & stall_id;
  assign stall_ex_o    = rst_n & stall_ex;
  assign bubble_ex_o   = rst_n & bubble_ex;
  assign flush_if_o    = rst_n & flush_if;
  assign flush_all_o   = rst_n & flush_all;
  assign redirect_o    = rst_n & redirect;
  assign redirect_pc_o = (rst_n && branch_sel) ? branch_target_i : target_q;
  assign epc_o         = epc_q;
  assign stall_cnt_o   = stall_cnt_q;

endmodule
